// File: rtl/pwm_ramp_ctrl.sv
// Ramps a PWM cutoff toward a requested target by STEP_SIZE every STEP_DIV cycles.
// Optional feature macro PWM_RAMP_IRQ_EN adds the sticky ramp_done_irq / irq_clear pair.
module pwm_ramp_ctrl #(
  parameter logic [15:0] STEP_DIV  = 16'd1000,
  parameter logic [7:0]  STEP_SIZE = 8'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_target,
  input  logic       wr_immediate,
  output logic       set_cutoff_en,
  output logic [7:0] cutoff_value,
  output logic       busy
`ifdef PWM_RAMP_IRQ_EN
  ,
  input  logic       irq_clear,
  output logic       ramp_done_irq
`endif
);

  localparam int unsigned CW = 8;
  localparam int unsigned TW = 16;
  localparam logic [CW-1:0] RESET_CUTOFF = 8'h7F;
  localparam logic [TW-1:0] TICK_LAST    = STEP_DIV - 16'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] current;
  logic [CW-1:0] current_nxt;
  logic [CW-1:0] target;
  logic [CW-1:0] target_nxt;
  logic [TW-1:0] tick;
  logic [TW-1:0] tick_nxt;

  logic          xfer;
  logic          jump;
  logic [CW:0]   step_up;
  logic [CW:0]   step_dn;
  logic [CW-1:0] step_val;

  logic          strobe_nxt;
  logic [CW-1:0] cutoff_nxt;
  logic          ready_nxt;
  logic          busy_nxt;

  // wr_ready is registered and tracks "state != STEP", so it is the live handshake qualifier
  assign xfer = wr_valid && wr_ready;
  assign jump = xfer && wr_immediate && (wr_target != current);

  // Next cutoff for a ramp step: 9-bit arithmetic, clamped to target in either direction
  always_comb begin
    step_up  = {1'b0, current} + {1'b0, STEP_SIZE};
    step_dn  = {1'b0, current} - {1'b0, STEP_SIZE};
    step_val = target;
    if (target > current) begin
      if (step_up < {1'b0, target}) begin
        step_val = step_up[CW-1:0];
      end
    end else begin
      if (!step_dn[CW] && (step_dn[CW-1:0] > target)) begin
        step_val = step_dn[CW-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt   = state;
    current_nxt = current;
    target_nxt  = target;
    tick_nxt    = tick;
    case (state)
      IDLE: begin
        if (xfer) begin
          target_nxt = wr_target;
          if (wr_target == current) begin
            state_nxt = IDLE;
          end else if (wr_immediate) begin
            current_nxt = wr_target;
            state_nxt   = IDLE;
          end else begin
            tick_nxt  = '0;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (xfer && ((wr_target == current) || wr_immediate)) begin
          target_nxt  = wr_target;
          current_nxt = wr_target;
          state_nxt   = IDLE;
        end else begin
          // A plain retarget keeps the tick count running; direction follows the new target
          if (xfer) begin
            target_nxt = wr_target;
          end
          tick_nxt = tick + 16'd1;
          if (tick == TICK_LAST) begin
            state_nxt = STEP;
          end
        end
      end
      STEP: begin
        current_nxt = step_val;
        if (step_val == target) begin
          state_nxt = IDLE;
        end else begin
          tick_nxt  = '0;
          state_nxt = WAIT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output next values; cutoff_value holds unless a strobe is issued
  always_comb begin
    strobe_nxt = 1'b0;
    cutoff_nxt = cutoff_value;
    ready_nxt  = (state_nxt != STEP);
    busy_nxt   = (state_nxt != IDLE);
    if (state == STEP) begin
      strobe_nxt = 1'b1;
      cutoff_nxt = step_val;
    end else if (jump) begin
      strobe_nxt = 1'b1;
      cutoff_nxt = wr_target;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      current       <= RESET_CUTOFF;
      target        <= RESET_CUTOFF;
      tick          <= '0;
      set_cutoff_en <= 1'b0;
      cutoff_value  <= RESET_CUTOFF;
      wr_ready      <= 1'b1;
      busy          <= 1'b0;
    end else begin
      current       <= current_nxt;
      target        <= target_nxt;
      tick          <= tick_nxt;
      set_cutoff_en <= strobe_nxt;
      cutoff_value  <= cutoff_nxt;
      wr_ready      <= ready_nxt;
      busy          <= busy_nxt;
    end
  end

`ifdef PWM_RAMP_IRQ_EN
  logic done_set;

  // Sticky completion flag; a new completion beats a simultaneous clear
  assign done_set = jump || ((state == STEP) && (step_val == target));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramp_done_irq <= 1'b0;
    end else if (done_set) begin
      ramp_done_irq <= 1'b1;
    end else if (irq_clear) begin
      ramp_done_irq <= 1'b0;
    end
  end
`endif

endmodule
